regfile_scheduler: RTL and testbench

- Sequences the 32-entry register file. Holds a scoreboard of pending destination registers and stalls operand issue on RAW/WAW hazards.
- Arbitrates the single register-file write port between the ALU and memory write-back requesters.
- Drives the register file's fetch enable, write enable, write address and write data.
- Sits between decode/issue and write-back, directly in front of the register file.

---
 rtl/regfile_scheduler.sv | 86 ++++++++
 tb/tb_regfile_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scheduler.sv
// regfile_scheduler: register-file scoreboard, RAW/WAW issue stall and ALU/memory write-port round-robin arbiter
module regfile_scheduler #(
    parameter int DataSize = 32,
    parameter int AddrSize = 5,
    parameter int RegNum   = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                freeze,
    input  logic                issue_valid,
    input  logic [2:0]          issue_src_mask,
    input  logic [AddrSize-1:0] issue_ra_addr,
    input  logic [AddrSize-1:0] issue_rb_addr,
    input  logic [AddrSize-1:0] issue_rt_addr,
    input  logic                issue_dst_valid,
    input  logic [AddrSize-1:0] issue_dst_addr,
    output logic                issue_ready,
    output logic                enable_reg_fetch,
    input  logic                alu_wb_valid,
    input  logic [AddrSize-1:0] alu_wb_addr,
    input  logic [DataSize-1:0] alu_wb_data,
    output logic                alu_wb_ready,
    input  logic                mem_wb_valid,
    input  logic [AddrSize-1:0] mem_wb_addr,
    input  logic [DataSize-1:0] mem_wb_data,
    output logic                mem_wb_ready,
    output logic                enable_reg_write,
    output logic                do_reg_write,
    output logic [AddrSize-1:0] write_reg_addr,
    output logic [DataSize-1:0] write_reg_data,
    output logic [RegNum-1:0]   busy_vector
);
    logic [RegNum-1:0]   busy_q, busy_d;
    logic                do_wr_q, do_wr_d, held_q, held_d, last_q, last_d;
    logic [AddrSize-1:0] waddr_q, waddr_d;
    logic [DataSize-1:0] wdata_q, wdata_d;
    logic                hazard, allow, alu_g, mem_g, commit;

    always_comb begin
        hazard = (issue_src_mask[0] && busy_q[issue_ra_addr]) ||
                 (issue_src_mask[1] && busy_q[issue_rb_addr]) ||
                 (issue_src_mask[2] && busy_q[issue_rt_addr]) ||
                 (issue_dst_valid && busy_q[issue_dst_addr]);
        issue_ready = !hazard && !freeze;
        enable_reg_fetch = issue_valid && issue_ready;
        enable_reg_write = !freeze;
        commit = !freeze && do_wr_q;
        // held_q marks a write that sat through a freeze; its release cycle only commits
        allow = !freeze && !held_q;
        alu_g = allow && alu_wb_valid && (!mem_wb_valid || last_q);
        mem_g = allow && mem_wb_valid && (!alu_wb_valid || !last_q);
        alu_wb_ready = alu_g;
        mem_wb_ready = mem_g;
        last_d = mem_g ? 1'b1 : alu_g ? 1'b0 : last_q;
        held_d = freeze && do_wr_q;
        do_wr_d = freeze ? do_wr_q : (alu_g || mem_g);
        waddr_d = mem_g ? mem_wb_addr : alu_g ? alu_wb_addr : waddr_q;
        wdata_d = mem_g ? mem_wb_data : alu_g ? alu_wb_data : wdata_q;
        busy_d = busy_q;
        if (commit) busy_d[waddr_q] = 1'b0;
        if (enable_reg_fetch && issue_dst_valid) busy_d[issue_dst_addr] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q  <= '0;
            do_wr_q <= 1'b0;
            held_q  <= 1'b0;
            last_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            busy_q  <= busy_d;
            do_wr_q <= do_wr_d;
            held_q  <= held_d;
            last_q  <= last_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign do_reg_write   = do_wr_q;
    assign write_reg_addr = waddr_q;
    assign write_reg_data = wdata_q;
    assign busy_vector    = busy_q;
endmodule

// File: tb/tb_regfile_scheduler.sv
// tb_regfile_scheduler: directed checks of scoreboard stalls, write arbitration, freeze hold and reset
module tb_regfile_scheduler;
    logic        clock = 1'b0;
    logic        reset, freeze, issue_valid, issue_dst_valid;
    logic [2:0]  issue_src_mask;
    logic [4:0]  issue_ra_addr, issue_rb_addr, issue_rt_addr, issue_dst_addr;
    logic        issue_ready, enable_reg_fetch;
    logic        alu_wb_valid, alu_wb_ready, mem_wb_valid, mem_wb_ready;
    logic [4:0]  alu_wb_addr, mem_wb_addr, write_reg_addr;
    logic [31:0] alu_wb_data, mem_wb_data, write_reg_data, busy_vector;
    logic        enable_reg_write, do_reg_write;
    logic [31:0] rf [32];
    int          checks = 0;
    int          errors = 0;

    regfile_scheduler dut (
        .clock(clock), .reset(reset), .freeze(freeze),
        .issue_valid(issue_valid), .issue_src_mask(issue_src_mask),
        .issue_ra_addr(issue_ra_addr), .issue_rb_addr(issue_rb_addr), .issue_rt_addr(issue_rt_addr),
        .issue_dst_valid(issue_dst_valid), .issue_dst_addr(issue_dst_addr),
        .issue_ready(issue_ready), .enable_reg_fetch(enable_reg_fetch),
        .alu_wb_valid(alu_wb_valid), .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data),
        .alu_wb_ready(alu_wb_ready),
        .mem_wb_valid(mem_wb_valid), .mem_wb_addr(mem_wb_addr), .mem_wb_data(mem_wb_data),
        .mem_wb_ready(mem_wb_ready),
        .enable_reg_write(enable_reg_write), .do_reg_write(do_reg_write),
        .write_reg_addr(write_reg_addr), .write_reg_data(write_reg_data),
        .busy_vector(busy_vector)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (enable_reg_write && do_reg_write) rf[write_reg_addr] <= write_reg_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        automatic logic       exp_mem [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        automatic logic [4:0] exp_addr [4] = '{5'd5, 5'd1, 5'd6, 5'd2};
        automatic int         ai = 1;
        automatic int         mi = 5;
        reset = 0; freeze = 0; issue_valid = 0; issue_dst_valid = 0; issue_src_mask = 0;
        issue_ra_addr = 0; issue_rb_addr = 0; issue_rt_addr = 0; issue_dst_addr = 0;
        alu_wb_valid = 0; alu_wb_addr = 0; alu_wb_data = 0;
        mem_wb_valid = 0; mem_wb_addr = 0; mem_wb_data = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1;
        #1;
        chk("rst_busy", busy_vector, 0);
        chk("rst_dowr", do_reg_write, 0);
        chk("rst_addr", write_reg_addr, 0);
        chk("rst_data", write_reg_data, 0);
        chk("rst_irdy", issue_ready, 1);
        chk("rst_ewr", enable_reg_write, 1);
        // mid-stream reset with r4..r7 pending and a write in the output register
        issue_valid = 1; issue_dst_valid = 1;
        for (int r = 4; r < 8; r++) begin
            issue_dst_addr = 5'(r);
            if (r == 7) begin
                alu_wb_valid = 1; alu_wb_addr = 1; alu_wb_data = 32'h55;
            end
            tick();
        end
        issue_valid = 0; issue_dst_valid = 0;
        chk("pre_busy", busy_vector, 32'h0000_00F0);
        chk("pre_dowr", do_reg_write, 1);
        #2 reset = 0;
        #1;
        chk("arst_busy", busy_vector, 0);
        chk("arst_dowr", do_reg_write, 0);
        chk("arst_addr", write_reg_addr, 0);
        @(posedge clock);
        #1 reset = 1;
        #1;
        chk("rel_alu_rdy", alu_wb_ready, 1);
        tick();
        alu_wb_valid = 0;
        chk("rel_dowr", do_reg_write, 1);
        chk("rel_addr", write_reg_addr, 1);
        tick();
        // RAW on r3
        issue_valid = 1; issue_dst_valid = 1; issue_dst_addr = 3;
        #1 chk("raw_fire", enable_reg_fetch, 1);
        tick();
        chk("raw_busy", busy_vector, 32'h8);
        issue_dst_valid = 0; issue_src_mask = 3'b001; issue_ra_addr = 3;
        alu_wb_valid = 1; alu_wb_addr = 3; alu_wb_data = 32'hDEAD_BEEF;
        #1;
        chk("raw_irdy0", issue_ready, 0);
        chk("raw_fetch0", enable_reg_fetch, 0);
        chk("raw_alu_rdy", alu_wb_ready, 1);
        tick();
        alu_wb_valid = 0;
        #1;
        chk("raw_dowr", do_reg_write, 1);
        chk("raw_waddr", write_reg_addr, 3);
        chk("raw_wdata", write_reg_data, 32'hDEAD_BEEF);
        chk("raw_busy_n", busy_vector, 32'h8);
        chk("raw_irdy_n", issue_ready, 0);
        tick();
        chk("raw_busy_clr", busy_vector, 0);
        chk("raw_irdy1", issue_ready, 1);
        chk("raw_fetch1", enable_reg_fetch, 1);
        chk("raw_rf3", rf[3], 32'hDEAD_BEEF);
        tick();
        issue_valid = 0; issue_src_mask = 0;
        chk("raw_idle", do_reg_write, 0);
        // round robin, last grant was ALU
        alu_wb_valid = 1; mem_wb_valid = 1;
        for (int i = 0; i < 4; i++) begin
            alu_wb_addr = 5'(ai); alu_wb_data = 32'hA000 + 32'(ai);
            mem_wb_addr = 5'(mi); mem_wb_data = 32'hB000 + 32'(mi);
            #1;
            chk("rr_mem_rdy", mem_wb_ready, exp_mem[i]);
            chk("rr_alu_rdy", alu_wb_ready, !exp_mem[i]);
            tick();
            chk("rr_addr", write_reg_addr, exp_addr[i]);
            if (exp_mem[i]) mi++; else ai++;
        end
        alu_wb_valid = 0; mem_wb_valid = 0;
        tick();
        chk("rr_rf5", rf[5], 32'hB005);
        chk("rr_rf2", rf[2], 32'hA002);
        chk("rr_busy", busy_vector, 0);
        // WAW on r7
        issue_valid = 1; issue_dst_valid = 1; issue_dst_addr = 7;
        #1 chk("waw_fire", enable_reg_fetch, 1);
        tick();
        chk("waw_busy", busy_vector, 32'h80);
        mem_wb_valid = 1; mem_wb_addr = 7; mem_wb_data = 32'h77;
        #1;
        chk("waw_irdy0", issue_ready, 0);
        chk("waw_mem_rdy", mem_wb_ready, 1);
        tick();
        mem_wb_valid = 0;
        #1 chk("waw_irdy_n", issue_ready, 0);
        tick();
        chk("waw_irdy1", issue_ready, 1);
        chk("waw_fetch1", enable_reg_fetch, 1);
        tick();
        issue_valid = 0; issue_dst_valid = 0;
        chk("waw_reset_busy", busy_vector, 32'h80);
        // freeze hold on r9
        issue_valid = 1; issue_dst_valid = 1; issue_dst_addr = 9;
        tick();
        issue_valid = 0; issue_dst_valid = 0;
        chk("frz_busy", busy_vector, 32'h280);
        alu_wb_valid = 1; alu_wb_addr = 9; alu_wb_data = 32'h1234;
        #1 chk("frz_alu_rdy", alu_wb_ready, 1);
        tick();
        alu_wb_valid = 0; freeze = 1;
        mem_wb_valid = 1; mem_wb_addr = 10; mem_wb_data = 32'hCAFE;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("frz_mem_rdy", mem_wb_ready, 0);
            chk("frz_ewr", enable_reg_write, 0);
            tick();
            chk("frz_dowr", do_reg_write, 1);
            chk("frz_addr", write_reg_addr, 9);
            chk("frz_data", write_reg_data, 32'h1234);
            chk("frz_busy9", busy_vector, 32'h280);
        end
        freeze = 0;
        #1;
        chk("rls_ewr", enable_reg_write, 1);
        chk("rls_mem_rdy0", mem_wb_ready, 0);
        tick();
        chk("rls_busy", busy_vector, 32'h80);
        chk("rls_rf9", rf[9], 32'h1234);
        chk("rls_dowr0", do_reg_write, 0);
        chk("rls_mem_rdy1", mem_wb_ready, 1);
        tick();
        mem_wb_valid = 0;
        chk("nb_addr", write_reg_addr, 10);
        chk("nb_dowr", do_reg_write, 1);
        tick();
        chk("nb_busy", busy_vector, 32'h80);
        chk("nb_rf10", rf[10], 32'hCAFE);
        // same-edge commit of r2 and issue with dst r2
        alu_wb_valid = 1; alu_wb_addr = 2; alu_wb_data = 32'h2222;
        tick();
        alu_wb_valid = 0;
        issue_valid = 1; issue_dst_valid = 1; issue_dst_addr = 2;
        #1;
        chk("se_irdy", issue_ready, 1);
        chk("se_dowr", do_reg_write, 1);
        chk("se_addr", write_reg_addr, 2);
        tick();
        issue_valid = 0; issue_dst_valid = 0;
        chk("se_busy", busy_vector, 32'h84);
        chk("se_rf2", rf[2], 32'h2222);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
